// File: rtl/micro_riscv_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : micro_riscv_mc_if
// Brief    : Instruction and data req/gnt/rvalid buses of the multi-cycle core.
// Revision : 1.0  initial release
// ============================================================================
interface micro_riscv_mc_if;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;

  logic        data_req_o;
  logic        data_we_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic [3:0]  data_be_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;

  modport master (
    output instr_req_o, instr_addr_o,
    input  instr_gnt_i, instr_rvalid_i, instr_rdata_i,
    output data_req_o, data_we_o, data_addr_o, data_wdata_o, data_be_o,
    input  data_gnt_i, data_rvalid_i, data_rdata_i
  );

  modport slave (
    input  instr_req_o, instr_addr_o,
    output instr_gnt_i, instr_rvalid_i, instr_rdata_i,
    input  data_req_o, data_we_o, data_addr_o, data_wdata_o, data_be_o,
    output data_gnt_i, data_rvalid_i, data_rdata_i
  );
endinterface
`default_nettype wire

// File: rtl/micro_riscv_mc.sv
`default_nettype none
// ============================================================================
// Module   : micro_riscv_mc
// Brief    : Multi-cycle RV32I-subset core with req/gnt/rvalid memory ports.
// Revision : 1.0  initial release
// ============================================================================
module micro_riscv_mc #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          CNT_WIDTH  = 32
) (
  input  wire logic                 clk_i,
  input  wire logic                 reset_i,
  micro_riscv_mc_if.master          bus,
  output logic                      cpu_finish_o,
  output logic                      cpu_illegal_o,
  output logic [CNT_WIDTH-1:0]      cycle_cnt_o,
  output logic [CNT_WIDTH-1:0]      instret_cnt_o
);

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_IWAIT = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_DWAIT = 3'd4,
    ST_HALT  = 3'd5
  } state_t;

  localparam logic [6:0]  c_op_lui    = 7'b0110111;
  localparam logic [6:0]  c_op_auipc  = 7'b0010111;
  localparam logic [6:0]  c_op_jal    = 7'b1101111;
  localparam logic [6:0]  c_op_jalr   = 7'b1100111;
  localparam logic [6:0]  c_op_branch = 7'b1100011;
  localparam logic [6:0]  c_op_load   = 7'b0000011;
  localparam logic [6:0]  c_op_store  = 7'b0100011;
  localparam logic [6:0]  c_op_imm    = 7'b0010011;
  localparam logic [6:0]  c_op_reg    = 7'b0110011;
  localparam logic [6:0]  c_op_system = 7'b1110011;
  localparam logic [31:0] c_ebreak    = 32'h0010_0073;
  localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [31:0]           r_pc;
  logic [31:0]           r_ir;
  logic [31:0]           r_daddr;
  logic [31:0]           r_dwdata;
  logic                  r_dwe;
  logic                  r_illegal;
  logic [CNT_WIDTH-1:0]  r_cycle;
  logic [CNT_WIDTH-1:0]  r_instret;
  logic [31:0]           r_rf [32];

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_rs1_val, w_rs2_val, w_pc4;

  logic        w_legal, w_wb_en, w_is_mem, w_mem_we, w_ebreak, w_taken, w_br_ok;
  logic [31:0] w_wb_data, w_next_pc, w_target, w_mem_addr;
  logic        w_retire;

  assign w_opcode  = r_ir[6:0];
  assign w_rd      = r_ir[11:7];
  assign w_f3      = r_ir[14:12];
  assign w_rs1     = r_ir[19:15];
  assign w_rs2     = r_ir[24:20];
  assign w_f7      = r_ir[31:25];
  assign w_imm_i   = {{20{r_ir[31]}}, r_ir[31:20]};
  assign w_imm_s   = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
  assign w_imm_b   = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
  assign w_imm_u   = {r_ir[31:12], 12'h000};
  assign w_imm_j   = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
  // x0 is held at zero by never being written, so reads need no special case
  assign w_rs1_val = r_rf[w_rs1];
  assign w_rs2_val = r_rf[w_rs2];
  assign w_pc4     = r_pc + 32'd4;

  always_comb begin
    w_legal    = 1'b0;
    w_wb_en    = 1'b0;
    w_wb_data  = 32'h0;
    w_next_pc  = w_pc4;
    w_target   = 32'h0;
    w_is_mem   = 1'b0;
    w_mem_we   = 1'b0;
    w_mem_addr = 32'h0;
    w_ebreak   = 1'b0;
    w_taken    = 1'b0;
    w_br_ok    = 1'b0;
    case (w_opcode)
      c_op_lui: begin
        w_legal   = 1'b1;
        w_wb_en   = 1'b1;
        w_wb_data = w_imm_u;
      end
      c_op_auipc: begin
        w_legal   = 1'b1;
        w_wb_en   = 1'b1;
        w_wb_data = r_pc + w_imm_u;
      end
      c_op_jal: begin
        w_target  = r_pc + w_imm_j;
        w_legal   = (w_target[1:0] == 2'b00);
        w_wb_en   = 1'b1;
        w_wb_data = w_pc4;
        w_next_pc = w_target;
      end
      c_op_jalr: begin
        w_target  = (w_rs1_val + w_imm_i) & ~32'd1;
        w_legal   = (w_f3 == 3'b000) && !w_target[1];
        w_wb_en   = 1'b1;
        w_wb_data = w_pc4;
        w_next_pc = w_target;
      end
      c_op_branch: begin
        w_target = r_pc + w_imm_b;
        case (w_f3)
          3'b000:  begin w_br_ok = 1'b1; w_taken = (w_rs1_val == w_rs2_val); end
          3'b001:  begin w_br_ok = 1'b1; w_taken = (w_rs1_val != w_rs2_val); end
          3'b100:  begin w_br_ok = 1'b1; w_taken = ($signed(w_rs1_val) <  $signed(w_rs2_val)); end
          3'b101:  begin w_br_ok = 1'b1; w_taken = ($signed(w_rs1_val) >= $signed(w_rs2_val)); end
          default: begin w_br_ok = 1'b0; w_taken = 1'b0; end
        endcase
        // a misaligned target only faults when the branch is actually taken
        w_legal = w_br_ok && !(w_taken && (w_target[1:0] != 2'b00));
        if (w_taken) w_next_pc = w_target;
      end
      c_op_load: begin
        w_mem_addr = w_rs1_val + w_imm_i;
        w_is_mem   = 1'b1;
        w_legal    = (w_f3 == 3'b010) && (w_mem_addr[1:0] == 2'b00);
      end
      c_op_store: begin
        w_mem_addr = w_rs1_val + w_imm_s;
        w_is_mem   = 1'b1;
        w_mem_we   = 1'b1;
        w_legal    = (w_f3 == 3'b010) && (w_mem_addr[1:0] == 2'b00);
      end
      c_op_imm: begin
        w_legal   = (w_f3 == 3'b000);
        w_wb_en   = 1'b1;
        w_wb_data = w_rs1_val + w_imm_i;
      end
      c_op_reg: begin
        w_legal = 1'b1;
        w_wb_en = 1'b1;
        case ({w_f7, w_f3})
          10'b0000000_000: w_wb_data = w_rs1_val + w_rs2_val;
          10'b0100000_000: w_wb_data = w_rs1_val - w_rs2_val;
          10'b0000000_001: w_wb_data = w_rs1_val << w_rs2_val[4:0];
          10'b0000000_100: w_wb_data = w_rs1_val ^ w_rs2_val;
          10'b0000000_101: w_wb_data = w_rs1_val >> w_rs2_val[4:0];
          10'b0100000_101: w_wb_data = $unsigned($signed(w_rs1_val) >>> w_rs2_val[4:0]);
          10'b0000000_110: w_wb_data = w_rs1_val | w_rs2_val;
          10'b0000000_111: w_wb_data = w_rs1_val & w_rs2_val;
          default: begin
            w_legal = 1'b0;
            w_wb_en = 1'b0;
          end
        endcase
      end
      c_op_system: begin
        w_legal  = (r_ir == c_ebreak);
        w_ebreak = (r_ir == c_ebreak);
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_retire = ((r_state == ST_EXEC) && w_legal && !w_is_mem) ||
                    ((r_state == ST_DWAIT) && bus.data_rvalid_i);

  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= ST_FETCH;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FETCH: if (bus.instr_gnt_i)    w_state_nxt = ST_IWAIT;
      ST_IWAIT: if (bus.instr_rvalid_i) w_state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (!w_legal || w_ebreak) w_state_nxt = ST_HALT;
        else if (w_is_mem)        w_state_nxt = ST_MEM;
        else                      w_state_nxt = ST_FETCH;
      end
      ST_MEM:   if (bus.data_gnt_i)     w_state_nxt = ST_DWAIT;
      ST_DWAIT: if (bus.data_rvalid_i)  w_state_nxt = ST_FETCH;
      ST_HALT:  w_state_nxt = ST_HALT;
      default:  w_state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_pc      <= RESET_ADDR;
      r_ir      <= 32'h0;
      r_daddr   <= 32'h0;
      r_dwdata  <= 32'h0;
      r_dwe     <= 1'b0;
      r_illegal <= 1'b0;
      r_cycle   <= '0;
      r_instret <= '0;
      for (int i = 0; i < 32; i++) r_rf[i] <= 32'h0;
    end else begin
      if (r_state != ST_HALT) r_cycle   <= r_cycle + c_cnt_one;
      if (w_retire)           r_instret <= r_instret + c_cnt_one;
      case (r_state)
        ST_IWAIT: if (bus.instr_rvalid_i) r_ir <= bus.instr_rdata_i;
        ST_EXEC: begin
          if (!w_legal) begin
            r_illegal <= 1'b1;
          end else if (w_is_mem) begin
            r_daddr  <= w_mem_addr;
            r_dwdata <= w_rs2_val;
            r_dwe    <= w_mem_we;
          end else if (!w_ebreak) begin
            r_pc <= w_next_pc;
            if (w_wb_en && (w_rd != 5'd0)) r_rf[w_rd] <= w_wb_data;
          end
        end
        ST_DWAIT: begin
          if (bus.data_rvalid_i) begin
            r_pc <= w_pc4;
            if (!r_dwe && (w_rd != 5'd0)) r_rf[w_rd] <= bus.data_rdata_i;
          end
        end
        default: ;
      endcase
    end
  end

  // requests are masked while reset is held so the bus is quiet during reset
  assign bus.instr_req_o  = (r_state == ST_FETCH) && !reset_i;
  assign bus.instr_addr_o = r_pc;
  assign bus.data_req_o   = (r_state == ST_MEM) && !reset_i;
  assign bus.data_we_o    = (r_state == ST_MEM) && !reset_i && r_dwe;
  assign bus.data_be_o    = ((r_state == ST_MEM) && !reset_i) ? 4'hF : 4'h0;
  assign bus.data_addr_o  = r_daddr;
  assign bus.data_wdata_o = r_dwdata;

  assign cpu_finish_o  = (r_state == ST_HALT);
  assign cpu_illegal_o = r_illegal;
  assign cycle_cnt_o   = r_cycle;
  assign instret_cnt_o = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_micro_riscv_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_micro_riscv_mc
// Brief    : Directed programs against variable-latency memory models.
// Revision : 1.0  initial release
// ============================================================================
module tb_micro_riscv_mc;
  logic        clk_i   = 1'b0;
  logic        reset_i = 1'b1;
  logic        cpu_finish_o;
  logic        cpu_illegal_o;
  logic [31:0] cycle_cnt_o;
  logic [31:0] instret_cnt_o;

  micro_riscv_mc_if bus ();

  micro_riscv_mc #(.RESET_ADDR(32'h0000_0000), .CNT_WIDTH(32)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .bus           (bus),
    .cpu_finish_o  (cpu_finish_o),
    .cpu_illegal_o (cpu_illegal_o),
    .cycle_cnt_o   (cycle_cnt_o),
    .instret_cnt_o (instret_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] imem [256];
  logic [31:0] dmem [256];

  int i_gnt_dly, i_rv_dly, d_gnt_dly, d_rv_dly;
  int i_age, i_cnt, d_age, d_cnt;
  logic i_pend, d_pend, keep_stale;
  logic [31:0] i_data, d_data, i_hold, d_hold_addr, d_hold_wdata;
  logic d_hold_we;
  int stable_err, d_req_seen, d_gnt_count;
  logic [31:0] st_addr, st_wdata;
  logic [3:0]  st_be;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory models: inputs change on the falling edge, sampled by the core on the rising edge
  initial begin
    bus.instr_gnt_i = 1'b0; bus.instr_rvalid_i = 1'b0; bus.instr_rdata_i = 32'h0;
    bus.data_gnt_i  = 1'b0; bus.data_rvalid_i  = 1'b0; bus.data_rdata_i  = 32'h0;
    i_pend = 1'b0; d_pend = 1'b0; i_age = 0; d_age = 0; i_cnt = 0; d_cnt = 0;
    keep_stale = 1'b0;
    forever begin
      @(negedge clk_i);
      bus.instr_gnt_i = 1'b0; bus.instr_rvalid_i = 1'b0;
      bus.data_gnt_i  = 1'b0; bus.data_rvalid_i  = 1'b0;
      if (reset_i) begin
        i_pend = 1'b0; i_age = 0; d_age = 0;
        if (!keep_stale) d_pend = 1'b0;
      end
      if (i_pend) begin
        if (i_cnt == 0) begin bus.instr_rvalid_i = 1'b1; bus.instr_rdata_i = i_data; i_pend = 1'b0; end
        else i_cnt--;
      end
      if (bus.instr_req_o) begin
        if (i_age == 0) i_hold = bus.instr_addr_o;
        else if (bus.instr_addr_o != i_hold) stable_err++;
        if (i_age >= i_gnt_dly) begin
          bus.instr_gnt_i = 1'b1; i_pend = 1'b1; i_cnt = i_rv_dly;
          i_data = imem[bus.instr_addr_o[9:2]]; i_age = 0;
        end else i_age++;
      end
      if (d_pend) begin
        if (d_cnt == 0) begin bus.data_rvalid_i = 1'b1; bus.data_rdata_i = d_data; d_pend = 1'b0; end
        else d_cnt--;
      end
      if (bus.data_req_o) begin
        d_req_seen++;
        if (d_age == 0) begin
          d_hold_addr = bus.data_addr_o; d_hold_wdata = bus.data_wdata_o; d_hold_we = bus.data_we_o;
        end else if ((bus.data_addr_o != d_hold_addr) || (bus.data_wdata_o != d_hold_wdata) ||
                     (bus.data_we_o != d_hold_we)) stable_err++;
        if (d_age >= d_gnt_dly) begin
          bus.data_gnt_i = 1'b1; d_gnt_count++; d_age = 0;
          if (bus.data_we_o) begin
            dmem[bus.data_addr_o[9:2]] = bus.data_wdata_o;
            st_addr = bus.data_addr_o; st_wdata = bus.data_wdata_o; st_be = bus.data_be_o;
          end
          d_pend = 1'b1; d_cnt = d_rv_dly; d_data = dmem[bus.data_addr_o[9:2]];
        end else d_age++;
      end
    end
  end

  task automatic clear_mem();
    for (int k = 0; k < 256; k++) begin imem[k] = 32'h0; dmem[k] = 32'h0; end
    st_addr = 32'h0; st_wdata = 32'h0; st_be = 4'h0;
  endtask

  task automatic wait_finish(input string tag);
    for (int c = 0; c < 2000 && !cpu_finish_o; c++) begin
      @(posedge clk_i); #1;
    end
    if (!cpu_finish_o) check_val({tag, "_timeout"}, 64'd0, 64'd1);
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  task automatic run_prog(input string tag, input int igd, input int ird, input int dgd, input int drd);
    i_gnt_dly = igd; i_rv_dly = ird; d_gnt_dly = dgd; d_rv_dly = drd;
    @(posedge clk_i); #2 reset_i = 1'b1;
    @(posedge clk_i); #1;
    check_val({tag, "_rst_ireq"},  bus.instr_req_o,  64'd0);
    check_val({tag, "_rst_dreq"},  bus.data_req_o,   64'd0);
    check_val({tag, "_rst_be"},    bus.data_be_o,    64'd0);
    check_val({tag, "_rst_we"},    bus.data_we_o,    64'd0);
    check_val({tag, "_rst_fin"},   cpu_finish_o,     64'd0);
    check_val({tag, "_rst_ill"},   cpu_illegal_o,    64'd0);
    check_val({tag, "_rst_cyc"},   cycle_cnt_o,      64'd0);
    check_val({tag, "_rst_ret"},   instret_cnt_o,    64'd0);
    check_val({tag, "_rst_pc"},    bus.instr_addr_o, 64'd0);
    @(posedge clk_i); #2 reset_i = 1'b0;
    stable_err = 0; d_req_seen = 0; d_gnt_count = 0;
    wait_finish(tag);
  endtask

  initial begin
    i_gnt_dly = 0; i_rv_dly = 0; d_gnt_dly = 0; d_rv_dly = 0;
    stable_err = 0; d_req_seen = 0; d_gnt_count = 0;
    clear_mem();

    // addi x1,x0,5 ; addi x2,x1,-3 ; add x3,x1,x2 ; ebreak
    imem[0] = 32'h0050_0093; imem[1] = 32'hFFD0_8113;
    imem[2] = 32'h0020_81B3; imem[3] = 32'h0010_0073;
    run_prog("p1", 0, 0, 0, 0);
    check_val("p1_x1",  dut.r_rf[1], 64'd5);
    check_val("p1_x2",  dut.r_rf[2], 64'd2);
    check_val("p1_x3",  dut.r_rf[3], 64'd7);
    check_val("p1_fin", cpu_finish_o, 64'd1);
    check_val("p1_ill", cpu_illegal_o, 64'd0);
    check_val("p1_ret", instret_cnt_o, 64'd4);
    check_val("p1_cyc", cycle_cnt_o, 64'd12);
    check_val("p1_pc",  bus.instr_addr_o, 64'hC);

    // same program; per instruction 4 FETCH + 3 IWAIT + 1 EXEC = 8 cycles
    run_prog("p2", 3, 2, 0, 0);
    check_val("p2_x3",   dut.r_rf[3], 64'd7);
    check_val("p2_ret",  instret_cnt_o, 64'd4);
    check_val("p2_cyc",  cycle_cnt_o, 64'd32);
    check_val("p2_hold", stable_err, 64'd0);

    // lui x5,0x12345 ; sw x5,8(x0) ; lw x6,8(x0) ; ebreak  (data side also delayed on a rerun)
    clear_mem();
    imem[0] = 32'h1234_52B7; imem[1] = 32'h0050_2423;
    imem[2] = 32'h0080_2303; imem[3] = 32'h0010_0073;
    run_prog("p3", 0, 0, 0, 0);
    check_val("p3_staddr", st_addr, 64'd8);
    check_val("p3_stbe",   st_be, 64'hF);
    check_val("p3_stdata", st_wdata, 64'h1234_5000);
    check_val("p3_x6",     dut.r_rf[6], 64'h1234_5000);
    check_val("p3_ret",    instret_cnt_o, 64'd4);
    check_val("p3_cyc",    cycle_cnt_o, 64'd16);
    clear_mem();
    imem[0] = 32'h1234_52B7; imem[1] = 32'h0050_2423;
    imem[2] = 32'h0080_2303; imem[3] = 32'h0010_0073;
    run_prog("p3d", 1, 1, 2, 3);
    check_val("p3d_x6",   dut.r_rf[6], 64'h1234_5000);
    check_val("p3d_hold", stable_err, 64'd0);

    // lw x1,2(x0) is misaligned
    clear_mem();
    imem[0] = 32'h0020_2083;
    run_prog("p4", 0, 0, 0, 0);
    check_val("p4_dreq", d_req_seen, 64'd0);
    check_val("p4_fin",  cpu_finish_o, 64'd1);
    check_val("p4_ill",  cpu_illegal_o, 64'd1);
    check_val("p4_ret",  instret_cnt_o, 64'd0);
    check_val("p4_x1",   dut.r_rf[1], 64'd0);
    check_val("p4_cyc",  cycle_cnt_o, 64'd3);

    // x1=1; x2=0x101; jal +12 -> 0x14: bne x0,x1,-8 -> 0x0C: addi x3,x0,9; 0x10: jalr x1,0(x2) -> 0x100: ebreak
    clear_mem();
    imem[0]  = 32'h0010_0093; imem[1] = 32'h1010_0113; imem[2] = 32'h00C0_006F;
    imem[3]  = 32'h0090_0193; imem[4] = 32'h0001_00E7; imem[5] = 32'hFE10_1CE3;
    imem[64] = 32'h0010_0073;
    run_prog("p5", 0, 0, 0, 0);
    check_val("p5_x3",  dut.r_rf[3], 64'd9);
    check_val("p5_x1",  dut.r_rf[1], 64'h14);
    check_val("p5_pc",  bus.instr_addr_o, 64'h100);
    check_val("p5_ill", cpu_illegal_o, 64'd0);
    check_val("p5_ret", instret_cnt_o, 64'd7);
    check_val("p5_cyc", cycle_cnt_o, 64'd21);

    // reset during DWAIT of lw x6,8(x0); the stale response (DEAD) must not land in x6
    clear_mem();
    imem[0] = 32'h0080_2303; imem[1] = 32'h0010_0073;
    dmem[2] = 32'h0000_DEAD;
    i_gnt_dly = 0; i_rv_dly = 0; d_gnt_dly = 0; d_rv_dly = 4;
    @(posedge clk_i); #2 reset_i = 1'b1;
    @(posedge clk_i); #2 reset_i = 1'b0;
    d_gnt_count = 0;
    for (int c = 0; c < 200 && d_gnt_count == 0; c++) begin
      @(posedge clk_i); #1;
    end
    check_val("p6_dgnt", (d_gnt_count > 0), 64'd1);
    #1 reset_i = 1'b1; keep_stale = 1'b1;
    dmem[2] = 32'h0000_5555; d_rv_dly = 0;
    @(posedge clk_i); #2 reset_i = 1'b0;
    #1;
    check_val("p6_pc",   bus.instr_addr_o, 64'd0);
    check_val("p6_cyc0", cycle_cnt_o, 64'd0);
    check_val("p6_ret0", instret_cnt_o, 64'd0);
    check_val("p6_ireq", bus.instr_req_o, 64'd1);
    wait_finish("p6");
    keep_stale = 1'b0;
    check_val("p6_x6",  dut.r_rf[6], 64'h5555);
    check_val("p6_ret", instret_cnt_o, 64'd2);
    check_val("p6_ill", cpu_illegal_o, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
